// File: rtl/glacier_scheduler.sv
// Frame-level scheduler for the glacier obstacle layer: spawns, moves and retires
// sprite instances once per frame and arbitrates the shared sprite ROM per pixel.
module glacier_scheduler #(
    parameter int          NUM_SLOTS    = 4,
    parameter int          SPRITE_SIZE  = 128,
    parameter int          SCREEN_W     = 1280,
    parameter int          SCREEN_H     = 720,
    parameter int          SPAWN_PERIOD = 90,
    parameter int          SPAWN_X_MIN  = 64,
    parameter int          SPAWN_Y      = 32,
    parameter int          STEP         = 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [15:0]                  i_x,
    input  logic [15:0]                  i_y,
    input  logic                         i_v_sync,
    input  logic                         i_is_finished,
    input  logic                         i_is_dead,
    output logic [NUM_SLOTS-1:0]         o_active,
    output logic                         o_busy,
    output logic                         o_sel_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] o_sel_id,
    output logic [4:0]                   o_sel_u,
    output logic [4:0]                   o_sel_v
);

    localparam int          IW    = $clog2(NUM_SLOTS);
    localparam int          TW    = $clog2(SPAWN_PERIOD + 1);
    localparam logic [15:0] X_LIM = 16'(SCREEN_W - SPRITE_SIZE);
    localparam logic [15:0] Y_LIM = 16'(SCREEN_H - SPRITE_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_SPAWN
    } state_t;

    state_t                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [TW-1:0]                 timer_q, timer_d;
    logic [15:0]                   lfsr_q, lfsr_d;
    logic [NUM_SLOTS-1:0]          act_q, act_d;
    logic [NUM_SLOTS-1:0][15:0]    x_q, x_d;
    logic [NUM_SLOTS-1:0][15:0]    y_q, y_d;

    logic                          vs_meta_q, vs_sync_q, vs_prev_q, tick_q;

    logic                          sel_valid_q, sel_valid_d;
    logic [IW-1:0]                 sel_id_q, sel_id_d;
    logic [4:0]                    sel_u_q, sel_u_d;
    logic [4:0]                    sel_v_q, sel_v_d;

    logic                          tick_accept;
    logic                          free_any;
    logic [IW-1:0]                 free_idx;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Spawn column from the fresh LFSR value, folded back on-screen if too far right.
    function automatic logic [15:0] spawn_x(input logic [9:0] r);
        logic [16:0] s;
        s = 17'(SPAWN_X_MIN) + {7'd0, r};
        if (s >= {1'b0, X_LIM}) begin
            s = s - 17'd512;
        end
        return s[15:0];
    endfunction

    assign tick_accept = tick_q && (state_q == S_IDLE) && !i_is_finished && !i_is_dead;

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        lfsr_d  = lfsr_q;
        act_d   = act_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (tick_accept) begin
                    state_d = S_MOVE;
                    idx_d   = '0;
                end
            end
            S_MOVE: begin
                if (act_q[idx_q]) begin
                    if (x_q[idx_q] >= X_LIM || y_q[idx_q] > Y_LIM) begin
                        act_d[idx_q] = 1'b0;
                    end else begin
                        x_d[idx_q] = x_q[idx_q] + 16'(STEP);
                        y_d[idx_q] = y_q[idx_q] + 16'(STEP);
                    end
                end
                if (idx_q == IW'(NUM_SLOTS - 1)) begin
                    state_d = S_SPAWN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_SPAWN: begin
                lfsr_d = lfsr_step(lfsr_q);
                // A full table keeps the timer at its terminal count so the spawn retries next frame.
                if (timer_q == TW'(SPAWN_PERIOD - 1)) begin
                    if (free_any) begin
                        act_d[free_idx] = 1'b1;
                        x_d[free_idx]   = spawn_x(lfsr_d[9:0]);
                        y_d[free_idx]   = 16'(SPAWN_Y);
                        timer_d         = '0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lowest-index hit wins: scan downward so the last assignment is the lowest slot.
    always_comb begin
        sel_valid_d = 1'b0;
        sel_id_d    = '0;
        sel_u_d     = '0;
        sel_v_d     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (act_q[i] &&
                i_x >= x_q[i] && {1'b0, i_x} < {1'b0, x_q[i]} + 17'(SPRITE_SIZE) &&
                i_y >= y_q[i] && {1'b0, i_y} < {1'b0, y_q[i]} + 17'(SPRITE_SIZE)) begin
                sel_valid_d = 1'b1;
                sel_id_d    = IW'(i);
                sel_u_d     = 5'((i_x - x_q[i]) >> 2);
                sel_v_d     = 5'((i_y - y_q[i]) >> 2);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            act_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            vs_meta_q   <= 1'b0;
            vs_sync_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            tick_q      <= 1'b0;
            sel_valid_q <= 1'b0;
            sel_id_q    <= '0;
            sel_u_q     <= '0;
            sel_v_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            lfsr_q      <= lfsr_d;
            act_q       <= act_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vs_meta_q   <= i_v_sync;
            vs_sync_q   <= vs_meta_q;
            vs_prev_q   <= vs_sync_q;
            tick_q      <= vs_sync_q & ~vs_prev_q;
            sel_valid_q <= sel_valid_d;
            sel_id_q    <= sel_id_d;
            sel_u_q     <= sel_u_d;
            sel_v_q     <= sel_v_d;
        end
    end

    assign o_active    = act_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_sel_valid = sel_valid_q;
    assign o_sel_id    = sel_id_q;
    assign o_sel_u     = sel_u_q;
    assign o_sel_v     = sel_v_q;

endmodule

// File: tb/tb_glacier_scheduler.sv
// Self-checking bench for glacier_scheduler: fixed vectors plus randomized pixel probes
// compared against a frame-level behavioural model of the glacier slots.
module tb_glacier_scheduler;

    localparam int NS = 4;
    localparam int P  = 1;
    localparam int XL = 1280 - 128;
    localparam int YL = 720 - 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] px, py;
    logic        v_sync, is_finished, is_dead;
    logic [NS-1:0] active;
    logic        busy, sel_valid;
    logic [1:0]  sel_id;
    logic [4:0]  sel_u, sel_v;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          mx[NS];
    int          my[NS];
    bit          mact[NS];
    int          mtimer;
    logic [15:0] mlfsr;

    glacier_scheduler #(.NUM_SLOTS(NS), .SPAWN_PERIOD(P)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_x(px), .i_y(py), .i_v_sync(v_sync),
        .i_is_finished(is_finished), .i_is_dead(is_dead),
        .o_active(active), .o_busy(busy), .o_sel_valid(sel_valid),
        .o_sel_id(sel_id), .o_sel_u(sel_u), .o_sel_v(sel_v)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mx[i] = 0; my[i] = 0; mact[i] = 1'b0;
        end
        mtimer = 0;
        mlfsr  = 16'hACE1;
    endtask

    task automatic model_frame(output bit ret0);
        int free;
        ret0 = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (mact[i]) begin
                if (mx[i] >= XL || my[i] > YL) begin
                    mact[i] = 1'b0;
                    if (i == 0) ret0 = 1'b1;
                end else begin
                    mx[i] += 1; my[i] += 1;
                end
            end
        end
        mlfsr = lstep(mlfsr);
        if (mtimer == P - 1) begin
            free = -1;
            for (int i = 0; i < NS; i++)
                if (!mact[i] && free < 0) free = i;
            if (free >= 0) begin
                mact[free] = 1'b1;
                mx[free]   = 64 + int'(mlfsr[9:0]);
                if (mx[free] >= XL) mx[free] -= 512;
                my[free]   = 32;
                mtimer     = 0;
            end
        end else begin
            mtimer++;
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = 0;
        for (int i = 0; i < NS; i++) m[i] = mact[i];
        return m;
    endfunction

    function automatic logic [31:0] model_arb(input int x, input int y);
        for (int i = 0; i < NS; i++) begin
            if (mact[i] && x >= mx[i] && x < mx[i] + 128 && y >= my[i] && y < my[i] + 128)
                return {19'd0, 1'b1, 2'(i), 5'((x - mx[i]) / 4), 5'((y - my[i]) / 4)};
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] dut_sel();
        return {19'd0, sel_valid, sel_id, sel_u, sel_v};
    endfunction

    task automatic probe(input string name, input int x, input int y);
        px = 16'(x); py = 16'(y);
        step();
        chk(name, dut_sel(), model_arb(x, y));
    endtask

    task automatic check_slots();
        int s;
        for (int i = 0; i < NS; i++) begin
            if (mact[i]) begin
                probe("corner_tl", mx[i], my[i]);
                probe("corner_br", mx[i] + 127, my[i] + 127);
                probe("left_out", mx[i] - 1, my[i]);
                probe("below_out", mx[i], my[i] + 128);
            end
        end
        for (int k = 0; k < 2; k++) begin
            s = int'($urandom_range(0, NS - 1));
            probe("rand_pix", mx[s] + int'($urandom_range(0, 135)) - 4,
                  my[s] + int'($urandom_range(0, 135)) - 4);
        end
    endtask

    // One vsync pulse; counts o_busy cycles and advances the model when accepted.
    task automatic frame(input bit accept, output bit ret0);
        int n = 0;
        v_sync = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step();
            if (busy) n++;
            if (c == 2) v_sync = 1'b0;
        end
        chk("busy_cycles", n, accept ? NS + 1 : 0);
        ret0 = 1'b0;
        if (accept) model_frame(ret0);
        chk("active_mask", {28'd0, active}, model_mask());
    endtask

    typedef struct {
        int dx; int dy; bit v; int u; int w;
    } vec_t;

    initial begin
        vec_t vecs[8];
        bit   r0;
        bit   seen;
        int   x0, extra, n;

        vecs[0] = '{5, 9, 1'b1, 1, 2};
        vecs[1] = '{128, 9, 1'b0, 0, 0};
        vecs[2] = '{0, 0, 1'b1, 0, 0};
        vecs[3] = '{127, 127, 1'b1, 31, 31};
        vecs[4] = '{-1, 0, 1'b0, 0, 0};
        vecs[5] = '{0, 128, 1'b0, 0, 0};
        vecs[6] = '{0, -1, 1'b0, 0, 0};
        vecs[7] = '{64, 64, 1'b1, 16, 16};

        // Reset with random inputs
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            px = 16'($urandom); py = 16'($urandom);
            v_sync = 1'($urandom); is_finished = 1'($urandom); is_dead = 1'($urandom);
            step();
            chk("reset_outputs", {16'd0, active, busy, sel_valid, sel_id, sel_u, sel_v}, 32'd0);
        end
        px = 0; py = 0; v_sync = 0; is_finished = 0; is_dead = 0;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            chk("busy_idle_after_reset", {31'd0, busy}, 32'd0);
        end

        // Tick 1: first spawn, then fixed pixel vectors around slot 0
        frame(1'b1, r0);
        chk("tick1_active", {28'd0, active}, 32'h1);
        x0 = mx[0];
        for (int i = 0; i < 8; i++) begin
            px = 16'(x0 + vecs[i].dx); py = 16'(32 + vecs[i].dy);
            step();
            chk("vec_sel", dut_sel(),
                vecs[i].v ? {19'd0, 1'b1, 2'd0, 5'(vecs[i].u), 5'(vecs[i].w)} : 32'd0);
        end

        // Tick 2: slot 0 moved diagonally by one, slot 1 spawned
        frame(1'b1, r0);
        chk("tick2_active", {28'd0, active}, 32'h3);
        px = 16'(x0 + 1); py = 16'd33;
        step();
        chk("tick2_slot0_origin", dut_sel(), {19'd0, 1'b1, 12'd0});
        check_slots();

        // Freeze: dead and finished flags drop every frame tick
        is_dead = 1'b1;
        for (int f = 0; f < 10; f++) frame(1'b0, r0);
        is_dead = 1'b0;
        check_slots();
        is_finished = 1'b1;
        for (int f = 0; f < 2; f++) frame(1'b0, r0);
        is_finished = 1'b0;
        frame(1'b1, r0);
        check_slots();

        // Fill all slots, then run until slot 0 retires and respawns in the same frame
        seen = 1'b0; extra = 0;
        for (int f = 0; f < 700 && extra < 3; f++) begin
            frame(1'b1, r0);
            check_slots();
            if (r0) begin
                seen = 1'b1;
                chk("retire_full_mask", {28'd0, active}, 32'hF);
                px = 16'(mx[0]); py = 16'd32;
                step();
                chk("respawn_slot0", dut_sel(), {19'd0, 1'b1, 12'd0});
            end
            if (seen) extra++;
        end
        chk("retire_seen", {31'd0, seen}, 32'd1);

        // Reset in the middle of a frame update
        v_sync = 1'b1;
        n = 0;
        while (!busy && n < 12) begin
            step(); n++;
        end
        chk("busy_before_abort", {31'd0, busy}, 32'd1);
        step();
        rst_n = 1'b0; v_sync = 1'b0;
        step();
        chk("abort_outputs", {16'd0, active, busy, sel_valid, sel_id, sel_u, sel_v}, 32'd0);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) step();
        frame(1'b1, r0);
        check_slots();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
